// File: rtl/usram_fifo_ctrl.sv
// rtl/usram_fifo_ctrl.sv - WE/RE FIFO controller driving a 64x18 uSRAM (write port C, read port A)
// Optional build macro USRAM_FIFO_CTRL_OUTREG_EN adds a Q output register (2-cycle read latency).
module usram_fifo_ctrl #(
    parameter int DEPTH     = 64,
    parameter int AFULL_TH  = 60,
    parameter int AEMPTY_TH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [17:0] data,
    input  logic        re,
    output logic [17:0] q,
    output logic        valid,
    output logic        full,
    output logic        afull,
    output logic        empty,
    output logic        aempty,
    output logic [6:0]  count,
    output logic        overflow,
    output logic        underflow,
    output logic [5:0]  ram_c_addr,
    output logic [17:0] ram_c_din,
    output logic        ram_c_wen,
    output logic        ram_c_blk,
    output logic [5:0]  ram_a_addr,
    output logic        ram_a_addr_en,
    output logic        ram_a_blk,
    output logic        ram_a_addr_srst_n,
    input  logic [17:0] ram_a_dout
);

    localparam logic [5:0] LAST_PTR = 6'(DEPTH - 1);
    localparam logic [6:0] DEPTH_C  = 7'(DEPTH);
    localparam logic [6:0] AFULL_C  = 7'(AFULL_TH);
    localparam logic [6:0] AEMPTY_C = 7'(AEMPTY_TH);

    logic [5:0] wr_ptr;
    logic [5:0] rd_ptr;
    logic [6:0] count_r;
    logic [6:0] count_next;
    logic       full_r;
    logic       afull_r;
    logic       empty_r;
    logic       aempty_r;
    logic       overflow_r;
    logic       underflow_r;
    logic       rd_pend;
    logic       wr_acc;
    logic       rd_acc;

    // Acceptance looks only at the registered flags; reset blocks both strobes.
    assign wr_acc = we & ~full_r & ~reset;
    assign rd_acc = re & ~empty_r & ~reset;

    always_comb begin
        count_next = count_r;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_r + 7'd1;
            2'b01:   count_next = count_r - 7'd1;
            default: count_next = count_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            full_r      <= 1'b0;
            afull_r     <= 1'b0;
            empty_r     <= 1'b1;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            rd_pend     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? 6'd0 : wr_ptr + 6'd1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? 6'd0 : rd_ptr + 6'd1;
            end
            count_r     <= count_next;
            full_r      <= (count_next == DEPTH_C);
            afull_r     <= (count_next >= AFULL_C);
            empty_r     <= (count_next == 7'd0);
            aempty_r    <= (count_next <= AEMPTY_C);
            overflow_r  <= we & full_r;
            underflow_r <= re & empty_r;
            rd_pend     <= rd_acc;
        end
    end

`ifdef USRAM_FIFO_CTRL_OUTREG_EN
    logic [17:0] q_r;
    logic        valid_r;

    // Capture the uSRAM word one cycle after the address enable; Q holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_pend;
            if (rd_pend) begin
                q_r <= ram_a_dout;
            end
        end
    end

    assign q     = q_r;
    assign valid = valid_r;
`else
    assign q     = ram_a_dout;
    assign valid = rd_pend;
`endif

    assign full              = full_r;
    assign afull             = afull_r;
    assign empty             = empty_r;
    assign aempty            = aempty_r;
    assign count             = count_r;
    assign overflow          = overflow_r;
    assign underflow         = underflow_r;
    assign ram_c_addr        = wr_ptr;
    assign ram_c_din         = data;
    assign ram_c_wen         = wr_acc;
    assign ram_c_blk         = 1'b1;
    assign ram_a_addr        = rd_ptr;
    assign ram_a_addr_en     = rd_acc;
    assign ram_a_blk         = 1'b1;
    assign ram_a_addr_srst_n = ~reset;

endmodule

// File: tb/tb_usram_fifo_ctrl.sv
// tb/tb_usram_fifo_ctrl.sv - scoreboard bench for usram_fifo_ctrl (DEPTH=64 and DEPTH=48 instances)
module tb_usram_fifo_ctrl;

`ifdef USRAM_FIFO_CTRL_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [17:0] d;
    } ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        we0 = 1'b0, re0 = 1'b0;
    logic [17:0] data0 = '0;
    logic [17:0] q0, ram_c_din0, ram_a_dout0;
    logic        valid0, full0, afull0, empty0, aempty0, ovf0, udf0;
    logic        ram_c_wen0, ram_c_blk0, ram_a_addr_en0, ram_a_blk0, srst0;
    logic [6:0]  count0;
    logic [5:0]  ram_c_addr0, ram_a_addr0;
    logic [17:0] mem0 [64];

    logic        we1 = 1'b0, re1 = 1'b0;
    logic [17:0] data1 = '0;
    logic [17:0] q1, ram_c_din1, ram_a_dout1;
    logic        valid1, full1, afull1, empty1, aempty1, ovf1, udf1;
    logic        ram_c_wen1, ram_c_blk1, ram_a_addr_en1, ram_a_blk1, srst1;
    logic [6:0]  count1;
    logic [5:0]  ram_c_addr1, ram_a_addr1;
    logic [17:0] mem1 [64];

    usram_fifo_ctrl dut0 (
        .clk(clk), .reset(reset), .we(we0), .data(data0), .re(re0), .q(q0), .valid(valid0),
        .full(full0), .afull(afull0), .empty(empty0), .aempty(aempty0), .count(count0),
        .overflow(ovf0), .underflow(udf0), .ram_c_addr(ram_c_addr0), .ram_c_din(ram_c_din0),
        .ram_c_wen(ram_c_wen0), .ram_c_blk(ram_c_blk0), .ram_a_addr(ram_a_addr0),
        .ram_a_addr_en(ram_a_addr_en0), .ram_a_blk(ram_a_blk0), .ram_a_addr_srst_n(srst0),
        .ram_a_dout(ram_a_dout0)
    );

    usram_fifo_ctrl #(.DEPTH(48), .AFULL_TH(44), .AEMPTY_TH(4)) dut1 (
        .clk(clk), .reset(reset), .we(we1), .data(data1), .re(re1), .q(q1), .valid(valid1),
        .full(full1), .afull(afull1), .empty(empty1), .aempty(aempty1), .count(count1),
        .overflow(ovf1), .underflow(udf1), .ram_c_addr(ram_c_addr1), .ram_c_din(ram_c_din1),
        .ram_c_wen(ram_c_wen1), .ram_c_blk(ram_c_blk1), .ram_a_addr(ram_a_addr1),
        .ram_a_addr_en(ram_a_addr_en1), .ram_a_blk(ram_a_blk1), .ram_a_addr_srst_n(srst1),
        .ram_a_dout(ram_a_dout1)
    );

    // Behavioural uSRAM: synchronous write on port C, registered read on port A.
    always @(posedge clk) begin
        if (ram_c_wen0) mem0[ram_c_addr0] <= ram_c_din0;
        if (ram_a_addr_en0) ram_a_dout0 <= mem0[ram_a_addr0];
        if (ram_c_wen1) mem1[ram_c_addr1] <= ram_c_din1;
        if (ram_a_addr_en1) ram_a_dout1 <= mem1[ram_a_addr1];
    end

    logic [17:0] m0_q [$];
    logic [17:0] m1_q [$];
    ent_t        sb0 [$];
    ent_t        sb1 [$];
    ent_t        e0, e1;
    logic        xo0, xu0;
    logic [5:0]  m1_wp = '0, m1_rp = '0;

    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            n_vec++;
            if (sb0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_valid: got spurious valid q=%05h at cycle %0d, want no valid", q0, cyc);
            end else begin
                e0 = sb0.pop_front();
                if (q0 !== e0.d || cyc != e0.due) begin
                    n_err++;
                    $display("FAIL sb0_data: got q=%05h at cycle %0d, want q=%05h at cycle %0d", q0, cyc, e0.d, e0.due);
                end
            end
        end else if (sb0.size() != 0 && sb0[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL sb0_missing: got no valid at cycle %0d, want q=%05h", cyc, sb0[0].d);
            void'(sb0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (valid1 === 1'b1) begin
            n_vec++;
            if (sb1.size() == 0) begin
                n_err++;
                $display("FAIL sb1_valid: got spurious valid q=%05h at cycle %0d, want no valid", q1, cyc);
            end else begin
                e1 = sb1.pop_front();
                if (q1 !== e1.d || cyc != e1.due) begin
                    n_err++;
                    $display("FAIL sb1_data: got q=%05h at cycle %0d, want q=%05h at cycle %0d", q1, cyc, e1.d, e1.due);
                end
            end
        end else if (sb1.size() != 0 && sb1[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL sb1_missing: got no valid at cycle %0d, want q=%05h", cyc, sb1[0].d);
            void'(sb1.pop_front());
        end
    end

    task automatic step0(input logic w, input logic r, input logic [17:0] d);
        logic wok, rok;
        we0 = w; re0 = r; data0 = d;
        xo0 = w && (m0_q.size() == 64);
        xu0 = r && (m0_q.size() == 0);
        wok = w && (m0_q.size() != 64);
        rok = r && (m0_q.size() != 0);
        if (rok) sb0.push_back('{due: cyc + LAT, d: m0_q.pop_front()});
        if (wok) m0_q.push_back(d);
        @(posedge clk);
        #1;
        we0 = 1'b0; re0 = 1'b0;
    endtask

    task automatic step1(input logic w, input logic r, input logic [17:0] d);
        logic wok, rok;
        we1 = w; re1 = r; data1 = d;
        wok = w && (m1_q.size() != 48);
        rok = r && (m1_q.size() != 0);
        if (rok) begin
            sb1.push_back('{due: cyc + LAT, d: m1_q.pop_front()});
            m1_rp = (m1_rp == 6'd47) ? 6'd0 : m1_rp + 6'd1;
        end
        if (wok) begin
            m1_q.push_back(d);
            m1_wp = (m1_wp == 6'd47) ? 6'd0 : m1_wp + 6'd1;
        end
        @(posedge clk);
        #1;
        we1 = 1'b0; re1 = 1'b0;
    endtask

    task automatic do_reset(input logic w);
        reset = 1'b1; we0 = w; re0 = w; data0 = 18'h3c3c3;
        #1;
        n_vec++;
        if ({ram_c_wen0, ram_a_addr_en0, srst0} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_strobes: got wen/aen/srst_n=%b, want 000", {ram_c_wen0, ram_a_addr_en0, srst0});
        end
        m0_q.delete();
        m1_q.delete();
        m1_wp = '0;
        m1_rp = '0;
        while (sb0.size() > 0 && sb0[sb0.size()-1].due > cyc) void'(sb0.pop_back());
        while (sb1.size() > 0 && sb1[sb1.size()-1].due > cyc) void'(sb1.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0; we0 = 1'b0; re0 = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        do_reset(1'b0);
        n_vec++;
        if (count0 !== 7'd0 || {full0, afull0, empty0, aempty0} !== 4'b0011) begin
            n_err++;
            $display("FAIL reset_state: got count=%0d flags=%b, want count=0 flags=0011", count0, {full0, afull0, empty0, aempty0});
        end
        n_vec++;
        if ({valid0, ovf0, udf0, srst0, ram_c_blk0, ram_a_blk0} !== 6'b000111) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, want 000111", {valid0, ovf0, udf0, srst0, ram_c_blk0, ram_a_blk0});
        end
    endtask

    task automatic test_basic();
        for (int i = 1; i <= 5; i++) begin
            step0(1'b1, 1'b0, 18'(i));
            n_vec++;
            if (aempty0 !== (i <= 4) || empty0 !== 1'b0) begin
                n_err++;
                $display("FAIL basic_aempty: got aempty=%b empty=%b at count %0d, want %b 0", aempty0, empty0, i, (i <= 4));
            end
        end
        n_vec++;
        if (count0 !== 7'd5) begin
            n_err++;
            $display("FAIL basic_count: got %0d, want 5", count0);
        end
        for (int i = 0; i < 5; i++) step0(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, '0);
        n_vec++;
        if (count0 !== 7'd0 || empty0 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_drain: got count=%0d empty=%b, want 0 1", count0, empty0);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 64; i++) begin
            step0(1'b1, 1'b0, 18'h00100 + 18'(i));
            n_vec++;
            if (afull0 !== (i + 1 >= 60) || full0 !== (i + 1 == 64)) begin
                n_err++;
                $display("FAIL full_flags: got afull=%b full=%b at count %0d", afull0, full0, i + 1);
            end
        end
        n_vec++;
        if (count0 !== 7'd64) begin
            n_err++;
            $display("FAIL full_count: got %0d, want 64", count0);
        end
        step0(1'b1, 1'b0, 18'h3ffff);
        n_vec++;
        if (ovf0 !== xo0 || ovf0 !== 1'b1 || count0 !== 7'd64 || full0 !== 1'b1) begin
            n_err++;
            $display("FAIL full_overflow: got ovf=%b count=%0d full=%b, want 1 64 1", ovf0, count0, full0);
        end
        step0(1'b0, 1'b0, '0);
        n_vec++;
        if (ovf0 !== 1'b0) begin
            n_err++;
            $display("FAIL full_ovf_pulse: got %b, want 0", ovf0);
        end
        step0(1'b1, 1'b1, 18'h3fffe);
        n_vec++;
        if (ovf0 !== 1'b1 || count0 !== 7'd63 || full0 !== 1'b0) begin
            n_err++;
            $display("FAIL full_we_re: got ovf=%b count=%0d full=%b, want 1 63 0", ovf0, count0, full0);
        end
        for (int i = 0; i < 63; i++) step0(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, '0);
    endtask

    task automatic test_underflow();
        step0(1'b1, 1'b1, 18'h2abcd);
        n_vec++;
        if (udf0 !== xu0 || udf0 !== 1'b1 || count0 !== 7'd1 || empty0 !== 1'b0) begin
            n_err++;
            $display("FAIL underflow: got udf=%b count=%0d empty=%b, want 1 1 0", udf0, count0, empty0);
        end
        step0(1'b0, 1'b0, '0);
        n_vec++;
        if (udf0 !== 1'b0) begin
            n_err++;
            $display("FAIL underflow_pulse: got %b, want 0", udf0);
        end
        step0(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) step0(1'b1, 1'b0, 18'h01000 + 18'(i));
        for (int i = 0; i < 100; i++) begin
            step0(1'b1, 1'b1, 18'h03000 + 18'(i));
            n_vec++;
            if (count0 !== 7'd32 || {full0, afull0, empty0, aempty0} !== 4'b0000) begin
                n_err++;
                $display("FAIL b2b_hold: got count=%0d flags=%b at step %0d, want 32 0000", count0, {full0, afull0, empty0, aempty0}, i);
            end
        end
        for (int i = 0; i < 32; i++) step0(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, '0);
    endtask

    task automatic test_depth48();
        for (int i = 0; i < 48; i++) begin
            step1(1'b1, 1'b0, 18'h08000 + 18'(i));
            n_vec++;
            if (full1 !== (i + 1 == 48)) begin
                n_err++;
                $display("FAIL d48_full: got full=%b at count %0d", full1, i + 1);
            end
        end
        for (int i = 0; i < 200; i++) begin
            step1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 18'($urandom));
            n_vec++;
            if (count1 !== 7'(m1_q.size()) || full1 !== (m1_q.size() == 48) || empty1 !== (m1_q.size() == 0)) begin
                n_err++;
                $display("FAIL d48_count: got count=%0d full=%b empty=%b, want count=%0d", count1, full1, empty1, m1_q.size());
            end
            n_vec++;
            if (ram_c_addr1 !== m1_wp || ram_a_addr1 !== m1_rp) begin
                n_err++;
                $display("FAIL d48_ptr: got wr=%0d rd=%0d, want wr=%0d rd=%0d", ram_c_addr1, ram_a_addr1, m1_wp, m1_rp);
            end
        end
        for (int i = 0; i < 60 && m1_q.size() > 0; i++) step1(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step1(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 20; i++) step0(1'b1, 1'b0, 18'h00500 + 18'(i));
        step0(1'b1, 1'b1, 18'h00600);
        do_reset(1'b1);
        n_vec++;
        if (empty0 !== 1'b1 || count0 !== 7'd0 || valid0 !== 1'b0) begin
            n_err++;
            $display("FAIL midburst_reset: got empty=%b count=%0d valid=%b, want 1 0 0", empty0, count0, valid0);
        end
        step0(1'b1, 1'b0, 18'h2aaaa);
        step0(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) step0(1'b0, 1'b0, '0);
        n_vec++;
        if (count0 !== 7'd0 || empty0 !== 1'b1) begin
            n_err++;
            $display("FAIL midburst_after: got count=%0d empty=%b, want 0 1", count0, empty0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_back_to_back();
        test_depth48();
        test_reset_midburst();
        n_vec++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d/%0d pending reads, want 0/0", sb0.size(), sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
